// File: rtl/saes64_result_checker.sv
// rtl/saes64_result_checker.sv - lockstep comparator for two FU result streams
// Buffers each side in its own FIFO and pairs heads for comparison; halts on the first mismatch.
module saes64_result_checker #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic                     g_clk,
   input  logic                     g_reset,
   input  logic                     a_ready,
   input  logic [XLEN-1:0]          a_rd,
   input  logic                     b_ready,
   input  logic [XLEN-1:0]          b_rd,
   input  logic                     clear,
   output logic                     cmp_valid,
   output logic                     cmp_match,
   output logic                     mismatch,
   output logic                     overflow,
   output logic                     halted,
   output logic [XLEN-1:0]          fail_a,
   output logic [XLEN-1:0]          fail_b,
   output logic [15:0]              pair_count,
   output logic [$clog2(DEPTH):0]   a_level,
   output logic [$clog2(DEPTH):0]   b_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_mem_q [DEPTH];
   logic [XLEN-1:0]   b_mem_q [DEPTH];
   logic [PW-1:0]     a_wp_q, a_rp_q, b_wp_q, b_rp_q;
   logic [LW-1:0]     a_cnt_q, b_cnt_q;
   logic              cmp_valid_q, cmp_match_q, mismatch_q, overflow_q;
   logic [XLEN-1:0]   fail_a_q, fail_b_q;
   logic [15:0]       pair_count_q;

   logic flush, pop, heads_eq;
   logic a_full, b_full, a_push, b_push, a_drop, b_drop;

   always_comb begin
      flush    = g_reset | clear;
      a_full   = (a_cnt_q == LW'(DEPTH));
      b_full   = (b_cnt_q == LW'(DEPTH));
      pop      = (state_q == S_RUN) && (a_cnt_q != '0) && (b_cnt_q != '0);
      heads_eq = (a_mem_q[a_rp_q] == b_mem_q[b_rp_q]);
      // A full FIFO still accepts a strobe when the same edge frees a slot.
      a_push   = a_ready && (!a_full || pop);
      b_push   = b_ready && (!b_full || pop);
      a_drop   = a_ready && a_full && !pop;
      b_drop   = b_ready && b_full && !pop;
   end

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = S_RUN;
      else if (pop && !heads_eq)
         state_d = S_HALT;
   end

   always_ff @(posedge g_clk) begin
      if (g_reset)
         state_q <= S_RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge g_clk) begin
      if (!flush && a_push)
         a_mem_q[a_wp_q] <= a_rd;
      if (!flush && b_push)
         b_mem_q[b_wp_q] <= b_rd;
   end

   always_ff @(posedge g_clk) begin
      if (flush) begin
         a_wp_q       <= '0;
         a_rp_q       <= '0;
         b_wp_q       <= '0;
         b_rp_q       <= '0;
         a_cnt_q      <= '0;
         b_cnt_q      <= '0;
         cmp_valid_q  <= 1'b0;
         cmp_match_q  <= 1'b0;
         mismatch_q   <= 1'b0;
         overflow_q   <= 1'b0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         pair_count_q <= '0;
      end else begin
         if (a_push)
            a_wp_q <= a_wp_q + PW'(1);
         if (b_push)
            b_wp_q <= b_wp_q + PW'(1);
         if (pop) begin
            a_rp_q <= a_rp_q + PW'(1);
            b_rp_q <= b_rp_q + PW'(1);
         end
         case ({a_push, pop})
            2'b10:   a_cnt_q <= a_cnt_q + LW'(1);
            2'b01:   a_cnt_q <= a_cnt_q - LW'(1);
            default: a_cnt_q <= a_cnt_q;
         endcase
         case ({b_push, pop})
            2'b10:   b_cnt_q <= b_cnt_q + LW'(1);
            2'b01:   b_cnt_q <= b_cnt_q - LW'(1);
            default: b_cnt_q <= b_cnt_q;
         endcase
         cmp_valid_q <= pop;
         cmp_match_q <= pop && heads_eq;
         if (a_drop || b_drop)
            overflow_q <= 1'b1;
         if (pop && (pair_count_q != 16'hFFFF))
            pair_count_q <= pair_count_q + 16'd1;
         // Only the first mismatch is captured; the FSM stops popping after it.
         if (pop && !heads_eq) begin
            mismatch_q <= 1'b1;
            fail_a_q   <= a_mem_q[a_rp_q];
            fail_b_q   <= b_mem_q[b_rp_q];
         end
      end
   end

   assign cmp_valid  = cmp_valid_q;
   assign cmp_match  = cmp_match_q;
   assign mismatch   = mismatch_q;
   assign overflow   = overflow_q;
   assign halted     = (state_q == S_HALT);
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign pair_count = pair_count_q;
   assign a_level    = a_cnt_q;
   assign b_level    = b_cnt_q;

endmodule

// File: doc/saes64_result_checker.md
SAES64_RESULT_CHECKER -- requirements
Module: saes64_result_checker

Interface
REQ-001 Parameter: DEPTH, default 4, entries per result FIFO; power of two, 2..16.
REQ-002 Parameter: XLEN, default 64, result width.
REQ-003 g_clk  in  1  single clock; all state updates on rising edge.
REQ-004 g_reset  in  1  reset; synchronous, active-high.
REQ-005 a_ready  in  1  result strobe from FU instance A.
REQ-006 a_rd  in  XLEN  result data from FU instance A, sampled when a_ready=1.
REQ-007 b_ready  in  1  result strobe from FU instance B.
REQ-008 b_rd  in  XLEN  result data from FU instance B, sampled when b_ready=1.
REQ-009 clear  in  1  synchronous flush of FIFOs, flags, counter; returns to RUN.
REQ-010 cmp_valid  out  1  one-cycle pulse: one result pair compared.
REQ-011 cmp_match  out  1  pair equality; meaningful only when cmp_valid=1, else 0.
REQ-012 mismatch  out  1  sticky: a compared pair differed.
REQ-013 overflow  out  1  sticky: a strobe arrived with its FIFO full.
REQ-014 halted  out  1  1 while in state HALT.
REQ-015 fail_a, fail_b  out  XLEN each  A/B data of first mismatching pair.
REQ-016 pair_count  out  16  number of pairs compared, saturating.
REQ-017 a_level, b_level  out  clog2(DEPTH)+1 each  current FIFO occupancy.

Function
REQ-018 Each input side SHALL have an independent FIFO; a strobe pushes its data at the edge ending the strobe cycle.
REQ-019 Strobe with its FIFO full and no pop that cycle SHALL drop the data and set overflow; FIFO contents unchanged.
REQ-020 Strobe with FIFO full and pop in the same cycle SHALL be accepted; occupancy stays DEPTH; overflow not set.
REQ-021 State machine: RUN, HALT; reset/clear enter RUN.
REQ-022 In RUN, when both FIFOs non-empty, both heads SHALL be popped together and compared at that edge.
REQ-023 Compare result SHALL be registered: cmp_valid=1 and cmp_match=(headA==headB) in the cycle after the pop.
REQ-024 Latency: simultaneous strobes in cycle N into empty FIFOs -> pop at end of N+1 -> cmp_valid in N+2.
REQ-025 Pops SHALL continue every cycle while both FIFOs are non-empty; throughput is one pair per cycle.
REQ-026 pair_count SHALL increment by 1 per pop, saturating at 0xFFFF.
REQ-027 On a mismatching pop: mismatch<=1, fail_a/fail_b<=heads, state->HALT, all at that edge.
REQ-028 In HALT: no pops, fail_a/fail_b frozen, strobes still pushed, overflow detection active; only clear or reset exits.
REQ-029 Strobes from one side only SHALL accumulate; no timeout, no comparison until the other side catches up.
REQ-030 Level outputs SHALL reflect occupancy after the latest edge; read/write pointers wrap modulo DEPTH.

Reset
REQ-031 g_reset=1 at an edge: both FIFOs empty, state RUN, all outputs 0 (cmp_valid, cmp_match, mismatch, overflow, halted, fail_a, fail_b, pair_count, levels).
REQ-032 clear SHALL have the identical effect to reset; strobes in a clear/reset cycle SHALL be discarded.
REQ-033 Reset or clear asserted mid-stream SHALL suppress any cmp_valid pulse pending from the prior edge's pop.
REQ-034 g_reset has priority over clear; clear has priority over all other events.

Verification
REQ-035 Reset, then a_ready=b_ready=1, a_rd=b_rd=0x0123456789ABCDEF in cycle 0 -> cmp_valid=1, cmp_match=1 in cycle 2; pair_count=1; mismatch=0.
REQ-036 Three A strobes (0x11,0x22,0x33) in cycles 0-2, then three B strobes with the same values in cycles 5-7 -> a_level peaks at 3; three cmp_valid pulses, all matching, in cycles 7-9; pair_count=3.
REQ-037 Pair 1 equal (0x5), pair 2 A=0xAA, B=0xAB -> cmp_match=0 on second pulse; mismatch=1, halted=1, fail_a=0xAA, fail_b=0xAB; further equal pairs produce no cmp_valid.
REQ-038 DEPTH=4: five A strobes with no B strobes -> a_level=4, overflow=1 after fifth; FIFO holds first four values.
REQ-039 Full A FIFO, B FIFO non-empty, A strobe in the same cycle as a pop -> strobe accepted, a_level stays 4, overflow=0.
REQ-040 In HALT with both levels >0, clear=1 for one cycle with a_ready=1 -> next cycle all outputs 0, levels 0, state RUN, the strobe discarded.
